// File: rtl/mem_access_sequencer.sv
// Sequences one MEM-stage load/store onto the data memory port, splitting misaligned
// halfword/word accesses into byte accesses when MISALIGN_SPLIT_EN is defined.

`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`define DM_OP_WD  3'd1
`define DM_OP_UH  3'd2
`define DM_OP_SH  3'd3
`define DM_OP_UB  3'd4
`define DM_OP_SB  3'd5
`endif

module mem_access_sequencer (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [`DM_OP_BIT-1:0] req_op,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_w_en,
  output logic [`DM_OP_BIT-1:0] mem_op,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

  state_e                  state_q, state_d;
  logic [`DM_OP_BIT-1:0]   op_q, op_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    op_valid, op_aligned, reject, accept, in_xfer, in_resp;

`ifdef MISALIGN_SPLIT_EN
  logic                    split_q, split_d;
  logic [1:0]              idx_q, idx_d, last_idx;
  logic [31:0]             buf_q, buf_d, split_rdata;
`endif

  assign in_xfer   = (state_q == StXfer);
  assign in_resp   = (state_q == StResp);
  assign req_ready = rst_n && (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  always_comb begin
    op_valid   = 1'b1;
    op_aligned = 1'b1;
    case (req_op)
      `DM_OP_WD:            op_aligned = (req_addr[1:0] == 2'b00);
      `DM_OP_UH, `DM_OP_SH: op_aligned = !req_addr[0];
      `DM_OP_UB, `DM_OP_SB: op_aligned = 1'b1;
      default:              op_valid   = 1'b0;
    endcase
  end

`ifdef MISALIGN_SPLIT_EN
  assign reject   = !op_valid;
  assign last_idx = (op_q == `DM_OP_WD) ? 2'd3 : 2'd1;

  always_comb begin
    case (op_q)
      `DM_OP_WD: split_rdata = buf_q;
      `DM_OP_SH: split_rdata = {{16{buf_q[15]}}, buf_q[15:0]};
      default:   split_rdata = {16'h0, buf_q[15:0]};
    endcase
  end
`else
  assign reject = !(op_valid && op_aligned);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MISALIGN_SPLIT_EN
    split_d = split_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = req_op;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = reject;
          rdata_d = '0;
`ifdef MISALIGN_SPLIT_EN
          split_d = !reject && !op_aligned;
          idx_d   = 2'd0;
          buf_d   = '0;
`endif
          state_d = reject ? StResp : StXfer;
        end
      end
      StXfer: begin
`ifdef MISALIGN_SPLIT_EN
        if (split_q) begin
          if (!we_q) buf_d[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
          idx_d = idx_q + 2'd1;
          if (idx_q == last_idx) state_d = StResp;
        end else begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = StResp;
        end
`else
        if (!we_q) rdata_d = mem_rdata;
        state_d = StResp;
`endif
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_en     = in_xfer;
    mem_w_en   = in_xfer && we_q;
    mem_op     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (in_xfer) begin
      mem_op    = op_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
`ifdef MISALIGN_SPLIT_EN
      if (split_q) begin
        mem_op    = `DM_OP_UB;
        mem_addr  = addr_q + {30'd0, idx_q};
        mem_wdata = {24'h0, wdata_q[{idx_q, 3'b000} +: 8]};
      end
`endif
    end
    resp_valid = in_resp;
    resp_err   = in_resp && err_q;
    resp_rdata = in_resp ? rdata_q : '0;
`ifdef MISALIGN_SPLIT_EN
    if (in_resp && split_q) resp_rdata = split_rdata;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_SPLIT_EN
      split_q <= 1'b0;
      idx_q   <= '0;
      buf_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MISALIGN_SPLIT_EN
      split_q <= split_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench for mem_access_sequencer: byte-array memory, byte-level golden model.
// Honours MISALIGN_SPLIT_EN the same way the design does.

`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`define DM_OP_WD  3'd1
`define DM_OP_UH  3'd2
`define DM_OP_SH  3'd3
`define DM_OP_UB  3'd4
`define DM_OP_SB  3'd5
`endif

module tb_mem_access_sequencer;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [`DM_OP_BIT-1:0] req_op;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_en;
  logic                  mem_w_en;
  logic [`DM_OP_BIT-1:0] mem_op;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  logic       mem_clr;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  mem_access_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_w_en   (mem_w_en),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: combinational read with extension, write at posedge; 256-byte wrap.
  logic [7:0] ma0, ma1, ma2, ma3;
  always_comb begin
    ma0 = mem_addr[7:0];
    ma1 = ma0 + 8'd1;
    ma2 = ma0 + 8'd2;
    ma3 = ma0 + 8'd3;
    mem_rdata = '0;
    case (mem_op)
      `DM_OP_WD: mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
      `DM_OP_UH: mem_rdata = {16'h0, mem[ma1], mem[ma0]};
      `DM_OP_SH: mem_rdata = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
      `DM_OP_UB: mem_rdata = {24'h0, mem[ma0]};
      `DM_OP_SB: mem_rdata = {{24{mem[ma0][7]}}, mem[ma0]};
      default:   mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_en && mem_w_en) begin
      case (mem_op)
        `DM_OP_WD: begin
          mem[ma0] <= mem_wdata[7:0];   mem[ma1] <= mem_wdata[15:8];
          mem[ma2] <= mem_wdata[23:16]; mem[ma3] <= mem_wdata[31:24];
        end
        `DM_OP_UH, `DM_OP_SH: begin
          mem[ma0] <= mem_wdata[7:0];   mem[ma1] <= mem_wdata[15:8];
        end
        `DM_OP_UB, `DM_OP_SB: mem[ma0] <= mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int op_size(input logic [`DM_OP_BIT-1:0] op);
    case (op)
      `DM_OP_WD:            return 4;
      `DM_OP_UH, `DM_OP_SH: return 2;
      `DM_OP_UB, `DM_OP_SB: return 1;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [`DM_OP_BIT-1:0] op, input logic [31:0] raw);
    case (op)
      `DM_OP_WD: return raw;
      `DM_OP_UH: return {16'h0, raw[15:0]};
      `DM_OP_SH: return {{16{raw[15]}}, raw[15:0]};
      `DM_OP_UB: return {24'h0, raw[7:0]};
      `DM_OP_SB: return {{24{raw[7]}}, raw[7:0]};
      default:   return 32'h0;
    endcase
  endfunction

  // One request end to end; expectations derived from the byte-level golden model.
  task automatic do_req(input logic [`DM_OP_BIT-1:0] op, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int          sz, nx, cyc, xf;
    logic        split, e_err, got;
    logic [7:0]  ix;
    logic [31:0] raw, e_rdata, e_addr, e_wdata;
    logic [`DM_OP_BIT-1:0] e_op;
    sz    = op_size(op);
    split = 1'b0;
    e_err = 1'b0;
    if (sz == 0) e_err = 1'b1;
    else if ((int'(addr[1:0]) % sz) != 0) begin
`ifdef MISALIGN_SPLIT_EN
      split = 1'b1;
`else
      e_err = 1'b1;
`endif
    end
    nx  = e_err ? 0 : (split ? sz : 1);
    raw = '0;
    for (int i = 0; i < sz; i++) begin
      ix = addr[7:0] + 8'(i);
      raw[8*i +: 8] = gold[ix];
    end
    e_rdata = (e_err || we) ? 32'h0 : extend(op, raw);

    @(negedge clk);
    check_eq("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = `DM_OP_BIT'($urandom); req_we = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    cyc = 0; xf = 0; got = 1'b0; rdata = '0; err = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        e_op    = split ? `DM_OP_UB : op;
        e_addr  = split ? addr + 32'(xf) : addr;
        e_wdata = split ? {24'h0, wdata[8*xf +: 8]} : wdata;
        check_eq("mem_op", 32'(mem_op), 32'(e_op));
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wdata", mem_wdata, e_wdata);
        check_eq("mem_w_en", {31'd0, mem_w_en}, {31'd0, we});
        xf++;
      end
      if (resp_valid) begin
        got   = 1'b1;
        rdata = resp_rdata;
        err   = resp_err;
        check_eq("resp_rdata", resp_rdata, e_rdata);
        check_eq("resp_err", {31'd0, resp_err}, {31'd0, e_err});
        check_eq("latency", 32'(cyc), 32'(nx + 1));
      end else begin
        check_eq("resp_idle_zero", resp_rdata | {31'd0, resp_err}, 32'h0);
      end
    end
    check_eq("resp_timeout", {31'd0, got}, 32'd1);
    check_eq("xfer_count", 32'(xf), 32'(nx));
    @(negedge clk);
    check_eq("resp_one_pulse", {31'd0, resp_valid}, 32'd0);
    check_eq("ready_after", {31'd0, req_ready}, 32'd1);

    if (we && !e_err) begin
      for (int i = 0; i < sz; i++) begin
        ix = addr[7:0] + 8'(i);
        gold[ix] = wdata[8*i +: 8];
      end
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          diffs;

  initial begin
    for (int i = 0; i < 256; i++) gold[i] = 8'h00;
    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_op = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_resp", {30'd0, resp_valid, resp_err} | resp_rdata, 32'd0);
    check_eq("rst_mem", {30'd0, mem_en, mem_w_en} | mem_addr | mem_wdata | 32'(mem_op), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;
    #1;
    check_eq("ready_post_rst", {31'd0, req_ready}, 32'd1);

    do_req(`DM_OP_WD, 1'b1, 32'h10, 32'hDEADBEEF, rd, er);
    do_req(`DM_OP_WD, 1'b0, 32'h10, 32'h0, rd, er);
    check_eq("tp_wd_load", rd, 32'hDEADBEEF);

    do_req(`DM_OP_WD, 1'b1, 32'h10, 32'h44332211, rd, er);
    do_req(`DM_OP_WD, 1'b1, 32'h14, 32'h88776655, rd, er);
    do_req(`DM_OP_WD, 1'b0, 32'h13, 32'h0, rd, er);
`ifdef MISALIGN_SPLIT_EN
    check_eq("tp_split_wd", rd, 32'h77665544);
`endif
    do_req(`DM_OP_UB, 1'b1, 32'h11, 32'h80, rd, er);
    do_req(`DM_OP_UB, 1'b1, 32'h12, 32'hFF, rd, er);
    do_req(`DM_OP_SH, 1'b0, 32'h11, 32'h0, rd, er);
`ifdef MISALIGN_SPLIT_EN
    check_eq("tp_sh", rd, 32'hFFFFFF80);
`endif
    do_req(`DM_OP_UH, 1'b0, 32'h11, 32'h0, rd, er);
`ifdef MISALIGN_SPLIT_EN
    check_eq("tp_uh", rd, 32'h0000FF80);
`endif
    do_req(`DM_OP_WD, 1'b1, 32'h0E, 32'hAABBCCDD, rd, er);
    do_req(`DM_OP_WD, 1'b0, 32'h0C, 32'h0, rd, er);
    do_req(`DM_OP_WD, 1'b0, 32'h10, 32'h0, rd, er);
    do_req(3'd7, 1'b0, 32'h10, 32'h0, rd, er);
    check_eq("tp_invalid_err", {31'd0, er}, 32'd1);
    do_req(`DM_OP_WD, 1'b0, 32'h02, 32'h0, rd, er);
`ifndef MISALIGN_SPLIT_EN
    check_eq("tp_misalign_err", {31'd0, er}, 32'd1);
`endif

    for (int n = 0; n < 200; n++) begin
      do_req(`DM_OP_BIT'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom, rd, er);
    end

    // Reset in the middle of a store: already committed bytes stay.
    @(negedge clk);
    req_valid = 1'b1; req_op = `DM_OP_WD; req_we = 1'b1; req_wdata = 32'h11223344;
`ifdef MISALIGN_SPLIT_EN
    req_addr = 32'h21;
`else
    req_addr = 32'h20;
`endif
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
`ifdef MISALIGN_SPLIT_EN
    repeat (2) @(negedge clk);
    gold[8'h21] = 8'h44;
    gold[8'h22] = 8'h33;
`endif
    check_eq("pre_rst_mem_en", {31'd0, mem_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    check_eq("midrst_resp", {31'd0, resp_valid}, 32'd0);
    check_eq("midrst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_ready_after", {31'd0, req_ready}, 32'd1);
    do_req(`DM_OP_WD, 1'b0, 32'h20, 32'h0, rd, er);

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) diffs++;
    check_eq("mem_final_diffs", 32'(diffs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Pipeline-side initiator for the synchronous data memory. It accepts one load/store request at a time from the MEM stage and drives the memory's `en`/`op`/`w_en`/`addr`/`data_in` port. It returns the load result through a valid/ready handshake. Misaligned halfword and word accesses are split into sequential byte accesses, because the memory only handles naturally aligned lanes. The block sits between the MEM-stage control and the data memory.

## Interface
- No parameters; op width is `` `DM_OP_BIT ``, op codes are `` `DM_OP_WD/UH/UB/SH/SB `` from Core.vh.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle, request accepted when `req_valid && req_ready` at posedge.
- `req_op` in `` `DM_OP_BIT ``: access width/extension.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, little-endian, low bytes used for UB/SB/UH/SH.
- `resp_valid` out 1: one-cycle completion pulse (loads and stores).
- `resp_rdata` out 32: load result, extended per op; 0 for stores.
- `resp_err` out 1: qualifies `resp_valid`; request was rejected without memory access.
- `mem_en`, `mem_w_en` out 1; `mem_op` out `` `DM_OP_BIT ``; `mem_addr`, `mem_wdata` out 32: to memory.
- `mem_rdata` in 32: combinational memory read data for current `mem_addr`/`mem_op`.

## Operation
- States: IDLE, XFER, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. On accept, latch op, we, addr, wdata. Clear byte buffer. Go to XFER.
- Classification at accept:
  - WD is aligned iff addr[1:0]==0.
  - UH/SH are aligned iff addr[0]==0.
  - UB/SB are always aligned.
  - Any other op code is invalid.
- Invalid op: skip XFER, go to RESP with err=1, rdata=0, no memory access.
- Aligned: a single XFER cycle drives `mem_op`=latched op, `mem_addr`=latched addr, `mem_w_en`=we, `mem_wdata`=wdata. Loads capture `mem_rdata` unmodified.
- Misaligned (split): byte counter idx runs 0..N-1, with N=4 for WD and N=2 for halves.
  - Each XFER cycle drives `mem_op`=`` `DM_OP_UB ``, `mem_addr`=addr+idx (mod 2^32), `mem_wdata`={24'h0, wdata[8·idx+7:8·idx]}, `mem_w_en`=we.
  - Loads capture `mem_rdata[7:0]` into buffer byte idx.
  - After idx==N-1, go to RESP.
- Split load result:
  - WD: buffer[31:0].
  - UH: {16'h0, buffer[15:0]}.
  - SH: {{16{buffer[15]}}, buffer[15:0]}.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `resp_rdata` and `resp_err` are valid only while `resp_valid`=1 and are 0 otherwise.
- `mem_en`=1 only in XFER. All mem outputs are 0 outside XFER.
- A split access crossing a word boundary (e.g. WD at addr[1:0]=3) hits two memory words. This is legal and handled identically.
- `req_*` inputs are ignored outside IDLE. A new request can be accepted in the cycle after RESP.

## Timing
- Accept at edge k.
- Aligned access:
  - XFER during cycle k..k+1.
  - Memory write commits at edge k+1.
  - Load data is sampled at edge k+1.
  - `resp_valid` is high during cycle k+1..k+2.
- Split access of N bytes: XFER occupies N cycles; `resp_valid` is high in the cycle after the last XFER. Latency is 3 cycles for a half and 5 for a word.
- Invalid/err request: `resp_valid` in the cycle after accept.
- Throughput: one aligned request per 3 cycles (IDLE, XFER, RESP).
- Reset values:
  - `req_ready`=0 while `rst_n`=0, then 1.
  - All other outputs are 0.
  - State is IDLE, counter 0, buffer 0.
- Reset mid-operation returns to IDLE immediately with no response. Bytes already written at prior edges remain in memory; no rollback.

## Configuration
- `MISALIGN_SPLIT_EN` defined: misaligned WD/UH/SH are split as above; `resp_err` is asserted only for invalid ops.
- Not defined: misaligned WD/UH/SH are rejected like invalid ops. There is no XFER, `mem_en` stays 0, and RESP follows in the next cycle with `resp_err`=1, `resp_rdata`=0. Split counter and buffer logic are not built.

## Test plan
- Aligned WD store 0xDEADBEEF to 0x10, then WD load 0x10: one `mem_en` cycle each; load response 0xDEADBEEF, latency 2, err 0.
- With memory word 0x10=0x44332211 and 0x14=0x88776655, split WD load at 0x13: four UB cycles at 0x13..0x16; response 0x77665544 at cycle 5.
- SH load at 0x11 with bytes 0x11=0x80, 0x12=0xFF: response 0xFFFFFF80. UH at same address: 0x0000FF80.
- WD store 0xAABBCCDD at 0x0E: memory bytes 0x0E=DD, 0x0F=CC, 0x10=BB, 0x11=AA; neighbouring bytes unchanged.
- Assert `rst_n` low after the second byte of a split WD store: `mem_en` and `resp_valid` drop at once; first two bytes written, last two unchanged; `req_ready`=1 after release.
- Op code outside DM_OP set, and (without `MISALIGN_SPLIT_EN`) WD at 0x02: `resp_err`=1, `resp_rdata`=0, `mem_en` never asserted.
